// File: rtl/byte_lane_transfer_engine.sv
// Byte-serial load/store engine between a DATA_W-bit register and byte-wide memory.
// Runtime length (1..NBYTES) and endianness; one byte moved per clock.
module byte_lane_transfer_engine #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 16,
  localparam int LEN_W  = $clog2(DATA_W / 8) + 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Write,
  input  logic [LEN_W-1:0]  Len,
  input  logic              BE,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [DATA_W-1:0] WData,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [7:0]        Mem_Data,
  output logic              Mem_WR,
  output logic              Mem_CS,
  input  logic [7:0]        MemIn
);

  localparam int NBYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t              state;
  logic [LEN_W-1:0]    k;
  logic                wr_q;
  logic [LEN_W-1:0]    len_q;
  logic                be_q;
  logic [ADDR_W-1:0]   base_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                len_ok;
  logic                last;
  logic [LEN_W-1:0]    next_k;
  logic [LEN_W-1:0]    acc_j;
  logic [LEN_W-1:0]    cur_j;
  logic [LEN_W-1:0]    nxt_j;
  logic [DATA_W-1:0]   keep_mask;
  logic [DATA_W-1:0]   rdata_ld;

  function automatic logic [7:0] lane_byte(input logic [DATA_W-1:0] w,
                                           input logic [LEN_W-1:0]  j);
    logic [DATA_W-1:0] s;
    s = w >> (8 * int'(j));
    return s[7:0];
  endfunction

  // Memory outputs are registered one cycle ahead: each edge loads the
  // address/data for the byte that the following cycle presents.
  always_comb begin
    len_ok    = (Len != '0) && (Len <= LEN_W'(NBYTES));
    acc_j     = BE ? (Len - LEN_W'(1)) : '0;
    next_k    = k + LEN_W'(1);
    last      = (k == (len_q - LEN_W'(1)));
    cur_j     = be_q ? (len_q - k - LEN_W'(1)) : k;
    nxt_j     = be_q ? (len_q - next_k - LEN_W'(1)) : next_k;
    keep_mask = ~({DATA_W{1'b1}} << (8 * int'(Len)));
    rdata_ld  = (RData & ~(DATA_W'(8'hFF) << (8 * int'(cur_j))))
              | (DATA_W'(MemIn) << (8 * int'(cur_j)));
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state       <= IDLE;
      k           <= '0;
      wr_q        <= 1'b0;
      len_q       <= '0;
      be_q        <= 1'b0;
      base_q      <= '0;
      wdata_q     <= '0;
      RData       <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Err         <= 1'b0;
      Mem_Address <= '0;
      Mem_Data    <= '0;
      Mem_WR      <= 1'b0;
      Mem_CS      <= 1'b1;
    end else begin
      Done <= 1'b0;
      Err  <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            if (len_ok) begin
              state       <= XFER;
              Busy        <= 1'b1;
              k           <= '0;
              wr_q        <= Write;
              len_q       <= Len;
              be_q        <= BE;
              base_q      <= BaseAddr;
              wdata_q     <= WData;
              Mem_CS      <= 1'b0;
              Mem_WR      <= Write;
              Mem_Address <= BaseAddr;
              Mem_Data    <= Write ? lane_byte(WData, acc_j) : '0;
              if (!Write) RData <= RData & keep_mask;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        XFER: begin
          if (!wr_q) RData <= rdata_ld;
          if (last) begin
            state    <= FIN;
            Done     <= 1'b1;
            Mem_CS   <= 1'b1;
            Mem_WR   <= 1'b0;
            Mem_Data <= '0;
          end else begin
            k           <= next_k;
            Mem_Address <= base_q + ADDR_W'(next_k);
            Mem_Data    <= wr_q ? lane_byte(wdata_q, nxt_j) : '0;
          end
        end
        FIN: begin
          state <= IDLE;
          Busy  <= 1'b0;
          k     <= '0;
        end
        default: begin
          state  <= IDLE;
          Busy   <= 1'b0;
          Mem_CS <= 1'b1;
          Mem_WR <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_lane_transfer_engine.sv
// Directed bench: a 32-bit engine and a 64-bit engine, each with a byte-wide
// behavioural memory (combinational read, write on rising edge).
module tb_byte_lane_transfer_engine;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset, Start, Write, BE;
  logic [2:0]  Len;
  logic [15:0] BaseAddr;
  logic [31:0] WData, RData;
  logic        Busy, Done, Err, Mem_WR, Mem_CS;
  logic [15:0] Mem_Address;
  logic [7:0]  Mem_Data, MemIn;
  logic [7:0]  mem32 [0:65535];

  logic        start64, write64, be64;
  logic [3:0]  len64;
  logic [7:0]  base64;
  logic [63:0] wdata64, rdata64;
  logic        busy64, done64, err64, wr64, cs64;
  logic [7:0]  addr64, mdata64, memin64;
  logic [7:0]  mem64 [0:255];

  byte_lane_transfer_engine #(.DATA_W(32), .ADDR_W(16)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Write(Write), .Len(Len),
    .BE(BE), .BaseAddr(BaseAddr), .WData(WData), .RData(RData), .Busy(Busy),
    .Done(Done), .Err(Err), .Mem_Address(Mem_Address), .Mem_Data(Mem_Data),
    .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MemIn(MemIn)
  );

  byte_lane_transfer_engine #(.DATA_W(64), .ADDR_W(8)) dut64 (
    .Clock(Clock), .Reset(Reset), .Start(start64), .Write(write64), .Len(len64),
    .BE(be64), .BaseAddr(base64), .WData(wdata64), .RData(rdata64), .Busy(busy64),
    .Done(done64), .Err(err64), .Mem_Address(addr64), .Mem_Data(mdata64),
    .Mem_WR(wr64), .Mem_CS(cs64), .MemIn(memin64)
  );

  always @(posedge Clock) if (!Mem_CS && Mem_WR) mem32[Mem_Address] <= Mem_Data;
  assign MemIn = mem32[Mem_Address];
  always @(posedge Clock) if (!cs64 && wr64) mem64[addr64] <= mdata64;
  assign memin64 = mem64[addr64];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Returns the cycle (counted from the accepting edge) in which Done rose,
  // or -1 on timeout, plus {CS,WR,Data,Address} seen in cycle 1.
  task automatic run32(input logic wr, input logic [2:0] len, input logic be,
                       input logic [15:0] addr, input logic [31:0] wd,
                       output int done_cyc, output logic [25:0] c1);
    Write = wr; Len = len; BE = be; BaseAddr = addr; WData = wd;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    c1 = {Mem_CS, Mem_WR, Mem_Data, Mem_Address};
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (Done) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  task automatic run64(input logic wr, input logic [3:0] len, input logic be,
                       input logic [7:0] addr, input logic [63:0] wd,
                       output int done_cyc);
    write64 = wr; len64 = len; be64 = be; base64 = addr; wdata64 = wd;
    start64 = 1'b1;
    tick();
    start64 = 1'b0;
    done_cyc = -1;
    for (int c = 1; c <= 20; c++) begin
      if (done64) begin
        done_cyc = c;
        break;
      end
      tick();
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          dc;
    int          ndone;
    logic [25:0] c1;

    Reset = 1'b0; Start = 1'b0; Write = 1'b0; BE = 1'b0; Len = '0;
    BaseAddr = '0; WData = '0;
    start64 = 1'b0; write64 = 1'b0; be64 = 1'b0; len64 = '0; base64 = '0; wdata64 = '0;
    tick(); tick();
    check("reset_ctl", {Busy, Done, Err, Mem_CS, Mem_WR}, 5'b00010);
    check("reset_addr", Mem_Address, 16'h0000);
    check("reset_mdata", Mem_Data, 8'h00);
    check("reset_rdata", RData, 32'h0);
    Reset = 1'b1;
    tick();

    // Little-endian store
    run32(1'b1, 3'd4, 1'b0, 16'h0010, 32'hA1B2C3D4, dc, c1);
    check("le_store_done_cyc", dc, 5);
    check("le_store_cycle1", c1, {1'b0, 1'b1, 8'hD4, 16'h0010});
    check("le_store_mem", {mem32[16'h13], mem32[16'h12], mem32[16'h11], mem32[16'h10]}, 32'hA1B2C3D4);
    check("le_store_rdata_kept", RData, 32'h0);
    check("idle_after_store", {Busy, Mem_CS}, 2'b01);

    // Big-endian load of the same bytes
    run32(1'b0, 3'd4, 1'b1, 16'h0010, 32'h0, dc, c1);
    check("be_load_done_cyc", dc, 5);
    check("be_load_cycle1", c1, {1'b0, 1'b0, 8'h00, 16'h0010});
    check("be_load_rdata", RData, 32'hD4C3B2A1);

    // Short little-endian load clears upper bytes
    run32(1'b0, 3'd2, 1'b0, 16'h0010, 32'h0, dc, c1);
    check("le2_load_done_cyc", dc, 3);
    check("le2_load_rdata", RData, 32'h0000C3D4);

    // Address wrap
    run32(1'b1, 3'd3, 1'b0, 16'hFFFF, 32'h00112233, dc, c1);
    check("wrap_done_cyc", dc, 4);
    check("wrap_mem", {mem32[16'h0001], mem32[16'h0000], mem32[16'hFFFF]}, 24'h112233);

    // Big-endian store, Len=3
    run32(1'b1, 3'd3, 1'b1, 16'h0030, 32'h00AABBCC, dc, c1);
    check("be_store_mem", {mem32[16'h30], mem32[16'h31], mem32[16'h32]}, 24'hAABBCC);
    check("be_store_cycle1", c1, {1'b0, 1'b1, 8'hAA, 16'h0030});

    // Illegal lengths
    Len = 3'd0; Start = 1'b1; tick(); Start = 1'b0;
    check("len0_err", {Err, Busy, Mem_CS}, 3'b101);
    tick();
    check("len0_err_clear", {Err, Busy, Mem_CS}, 3'b001);
    Len = 3'd5; Start = 1'b1; tick(); Start = 1'b0;
    check("len5_err", {Err, Busy, Mem_CS}, 3'b101);
    tick();
    check("len5_err_clear", {Err, Busy, Mem_CS}, 3'b001);

    // Start held high through XFER: exactly one Done
    Write = 1'b1; Len = 3'd2; BE = 1'b0; BaseAddr = 16'h0040; WData = 32'h0000BEEF;
    Start = 1'b1;
    tick();
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      if (Done) begin
        ndone++;
        check("held_fin_busy", Busy, 1'b1);
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
    check("held_done_count", ndone, 1);
    check("held_mem", {mem32[16'h41], mem32[16'h40]}, 16'hBEEF);

    // Reset abort during a Len=4 store after two bytes
    run32(1'b1, 3'd4, 1'b0, 16'h0020, 32'h0, dc, c1);
    Write = 1'b1; Len = 3'd4; BE = 1'b0; BaseAddr = 16'h0020; WData = 32'h55667788;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    tick();
    Reset = 1'b0;
    tick();
    check("abort_ctl", {Busy, Done, Err, Mem_CS, Mem_WR}, 5'b00010);
    check("abort_addr_data", {Mem_Address, Mem_Data}, 24'h0);
    check("abort_rdata", RData, 32'h0);
    Reset = 1'b1;
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      if (Done) ndone++;
      tick();
    end
    check("abort_no_done", ndone, 0);
    check("abort_mem", {mem32[16'h23], mem32[16'h22], mem32[16'h21], mem32[16'h20]}, 32'h00007788);

    // 64-bit: BE store then LE load of 8 bytes
    run64(1'b1, 4'd8, 1'b1, 8'h40, 64'h0102030405060708, dc);
    check("w64_store_done_cyc", dc, 9);
    check("w64_store_mem0_7", {mem64[8'h40], mem64[8'h47]}, 16'h0108);
    run64(1'b0, 4'd8, 1'b0, 8'h40, 64'h0, dc);
    check("w64_load_done_cyc", dc, 9);
    check("w64_load_rdata", rdata64, 64'h0807060504030201);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
